busmaster030: RTL

Synchronous 68030-style bus initiator. Accepts single-operand read/write requests from an on-board master, such as a DMA engine or debug port, and runs asynchronous-protocol bus cycles (nAS/nDS/RnW/SIZ) against the existing responders. It terminates each cycle on nDsack, nSterm or nBerr. Supports dynamic bus sizing: operands are split across 8-, 16- or 32-bit ports exactly as the CPU does.

---
 rtl/busmaster030_pkg.sv | 49 ++++
 rtl/busmaster030_if.sv | 47 ++++
 rtl/busmaster030_lanes.sv | 45 ++++
 rtl/busmaster030.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/busmaster030_pkg.sv
// ---------------------------------------------------------------------------
// wrap030_bus_pkg : shared types and encodings for the 68030-style bus master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wrap030_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ASSERT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEGATE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] SIZ_LONG    = 2'b00;
  localparam logic [1:0] SIZ_BYTE    = 2'b01;
  localparam logic [1:0] SIZ_WORD    = 2'b10;
  localparam logic [1:0] SIZ_ILLEGAL = 2'b11;

  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // Port width in bytes; 0 means no acknowledge present.
  function automatic logic [2:0] dsack_width(input logic [1:0] ndsack);
    case (ndsack)
      DSACK_32: dsack_width = 3'd4;
      DSACK_16: dsack_width = 3'd2;
      DSACK_8:  dsack_width = 3'd1;
      default:  dsack_width = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
    case (siz)
      SIZ_LONG: siz_bytes = 3'd4;
      SIZ_BYTE: siz_bytes = 3'd1;
      SIZ_WORD: siz_bytes = 3'd2;
      default:  siz_bytes = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/busmaster030_if.sv
// ---------------------------------------------------------------------------
// busmaster030_if : request/response port and 68030 bus signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface busmaster030_if;

  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic [31:0] reqData;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;

  logic [31:0] busAddr;
  logic [1:0]  busSiz;
  logic        busRnW;
  logic        nAS;
  logic        nDS;
  logic [31:0] busDataOut;
  logic        busDataOe;
  logic [31:0] busDataIn;
  logic [1:0]  nDsack;
  logic        nSterm;
  logic        nBerr;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqSize, reqData,
    input  busDataIn, nDsack, nSterm, nBerr,
    output reqReady, rspValid, rspData, rspErr,
    output busAddr, busSiz, busRnW, nAS, nDS, busDataOut, busDataOe
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqSize, reqData,
    output busDataIn, nDsack, nSterm, nBerr,
    input  reqReady, rspValid, rspData, rspErr,
    input  busAddr, busSiz, busRnW, nAS, nDS, busDataOut, busDataOe
  );

endinterface

`default_nettype wire

// File: rtl/busmaster030_lanes.sv
// ---------------------------------------------------------------------------
// busmaster030_lanes : write replication and read lane extraction per sub-cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module busmaster030_lanes
  import wrap030_bus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  rem,
  input  logic [2:0]  port_w,
  input  logic [31:0] data_in,
  input  logic [31:0] operand,
  output logic [2:0]  step,
  output logic [31:0] rd_bytes,
  output logic [31:0] wr_data
);

  logic [1:0] off;
  logic [2:0] avail;

  always_comb begin
    case (port_w)
      3'd4:    off = addr_lo;
      3'd2:    off = {1'b0, addr_lo[0]};
      default: off = 2'd0;
    endcase
    avail = port_w - {1'b0, off};
    step  = (rem < avail) ? rem : avail;

    // Left-align the first addressed lane, then keep only the bytes moved.
    rd_bytes = (data_in << {off, 3'b000}) >> {3'd4 - step, 3'b000};

    case (rem)
      3'd1:    wr_data = {4{operand[7:0]}};
      3'd2:    wr_data = {2{operand[15:0]}};
      3'd3:    wr_data = {operand[23:16], operand[23:0]};
      default: wr_data = operand;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/busmaster030.sv
// ---------------------------------------------------------------------------
// busmaster030 : 68030-style bus initiator with dynamic bus sizing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module busmaster030
  import wrap030_bus_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic           sysClk,
  input  logic           reset,
  busmaster030_if.master bus
);

  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [31:0] addr_q;
  logic [31:0] buf_q;
  logic [2:0]  rem_q;
  logic [2:0]  step_q;
  logic        wr_q;
  logic        err_q;
  logic [7:0]  tmo_q;

  logic        illegal;
  logic [2:0]  port_w;
  logic        term_berr;
  logic        term_ok;
  logic        timed_out;
  logic        bus_quiet;
  logic [2:0]  step_n;
  logic [31:0] rd_bytes;
  logic [31:0] wr_data;

  assign illegal   = (bus.reqSize == SIZ_ILLEGAL)
                  || (bus.reqSize == SIZ_WORD && bus.reqAddr[0])
                  || (bus.reqSize == SIZ_LONG && bus.reqAddr[1:0] != 2'b00);
  assign term_berr = !bus.nBerr;
  assign port_w    = !bus.nSterm ? 3'd4 : dsack_width(bus.nDsack);
  assign term_ok   = (port_w != 3'd0);
  assign timed_out = (tmo_q >= TMO_LAST);
  assign bus_quiet = (bus.nDsack == DSACK_NONE) && bus.nSterm;

  busmaster030_lanes u_lanes (
    .addr_lo  (addr_q[1:0]),
    .rem      (rem_q),
    .port_w   (port_w),
    .data_in  (bus.busDataIn),
    .operand  (buf_q),
    .step     (step_n),
    .rd_bytes (rd_bytes),
    .wr_data  (wr_data)
  );

  always_ff @(posedge sysClk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.reqValid) state_nx = illegal ? ST_DONE : ST_ADDR;
      ST_ADDR:   state_nx = ST_ASSERT;
      ST_ASSERT: state_nx = ST_WAIT;
      ST_WAIT:   if (term_berr || term_ok || timed_out) state_nx = ST_NEGATE;
      ST_NEGATE: if (bus_quiet) state_nx = (!err_q && rem_q != step_q) ? ST_ADDR : ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase

    bus.reqReady   = (state == ST_IDLE) && !reset;
    bus.rspValid   = (state == ST_DONE);
    bus.rspErr     = (state == ST_DONE) && err_q;
    bus.rspData    = (state == ST_DONE && !wr_q) ? buf_q : 32'd0;
    bus.busAddr    = addr_q;
    bus.busSiz     = rem_q[1:0];
    bus.busRnW     = !wr_q;
    bus.nAS        = !(state == ST_ASSERT || state == ST_WAIT);
    bus.nDS        = !(state == ST_WAIT || (state == ST_ASSERT && !wr_q));
    bus.busDataOe  = wr_q && (state == ST_ADDR || state == ST_ASSERT ||
                              state == ST_WAIT || state == ST_NEGATE);
    bus.busDataOut = bus.busDataOe ? wr_data : 32'd0;
  end

  // Address and count advance only when leaving NEGATE so the bus stays stable.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      addr_q <= 32'd0;
      buf_q  <= 32'd0;
      rem_q  <= 3'd0;
      step_q <= 3'd0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.reqValid) begin
            addr_q <= bus.reqAddr;
            rem_q  <= siz_bytes(bus.reqSize);
            wr_q   <= bus.reqWrite;
            buf_q  <= bus.reqWrite ? bus.reqData : 32'd0;
            err_q  <= illegal;
            step_q <= 3'd0;
          end
        end
        ST_ADDR:   tmo_q <= 8'd0;
        ST_ASSERT: tmo_q <= tmo_q + 8'd1;
        ST_WAIT: begin
          tmo_q <= tmo_q + 8'd1;
          if (term_berr) begin
            err_q  <= 1'b1;
            step_q <= 3'd0;
          end else if (term_ok) begin
            step_q <= step_n;
            if (!wr_q) buf_q <= (buf_q << {step_n, 3'b000}) | rd_bytes;
          end else if (timed_out) begin
            err_q  <= 1'b1;
            step_q <= 3'd0;
          end
        end
        ST_NEGATE: begin
          if (bus_quiet) begin
            addr_q <= addr_q + 32'(step_q);
            rem_q  <= rem_q - step_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
